// File: rtl/packet_buffer_reader.sv
// ---------------------------------------------------------------------------
// packet_buffer_reader
// Streams a byte range out of the packet buffer BRAM. It issues reads with
// ring wrap-around and absorbs the fixed BRAM read latency in a small
// credit-controlled FIFO. The result is a valid/ready byte stream with a
// last-byte marker.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   start          : one-cycle command strobe (ignored while busy)
//   start_addr     : first byte address of the range
//   len            : byte count (0 gives a bare done pulse)
//   busy           : high while flushing, reading or draining
//   done           : one-cycle pulse after the stream completes
//   ram_read_req   : read strobe to the BRAM manager
//   ram_read_addr  : read address
//   ram_read_ready : read data valid, READ_LATENCY cycles after the request
//   ram_read_out   : read data
//   out_valid      : stream byte valid
//   out_data       : stream byte (FIFO head)
//   out_last       : final byte of the stream, qualified by out_valid
//   out_ready      : downstream accepts the byte
// ---------------------------------------------------------------------------
module packet_buffer_reader #(
    parameter int RAM_SIZE     = 2048,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_WIDTH    = 11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(RAM_SIZE)-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]        len,
    output logic                        busy,
    output logic                        done,
    output logic                        ram_read_req,
    output logic [$clog2(RAM_SIZE)-1:0] ram_read_addr,
    input  logic                        ram_read_ready,
    input  logic [7:0]                  ram_read_out,
    output logic                        out_valid,
    output logic [7:0]                  out_data,
    output logic                        out_last,
    input  logic                        out_ready
);

    localparam int AW = $clog2(RAM_SIZE);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
    localparam int FW = $clog2(READ_LATENCY + 1) + 1;

    localparam logic [AW-1:0]        ADDR_LAST  = AW'(RAM_SIZE - 1);
    localparam logic [PW-1:0]        PTR_LAST   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]        CREDITS    = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0]        FLUSH_LAST = FW'(READ_LATENCY);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [FW-1:0]        flush_cnt_r;
    logic [AW-1:0]        addr_r;
    logic [LEN_WIDTH-1:0] issue_cnt_r;
    logic [LEN_WIDTH-1:0] out_cnt_r;
    logic [CW-1:0]        inflight_r;
    logic [CW-1:0]        fifo_count_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [7:0]           fifo_mem_r [FIFO_DEPTH];
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 req_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 out_valid_s;

    // State register; the flush counter times out stale BRAM responses after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FW'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                if (start && (len != {LEN_WIDTH{1'b0}})) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (req_s && (issue_cnt_r == LEN_ONE)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (out_cnt_r == LEN_ONE)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_FLUSH;
        endcase
    end

    // Output/control decode. Credits use registered counts only, so a pop in
    // the same cycle never frees a slot early.
    always_comb begin
        accept_s = 1'b0;
        req_s    = 1'b0;
        case (state_r)
            ST_READ: begin
                accept_s = 1'b1;
                if (((inflight_r + fifo_count_r) < CREDITS) && (issue_cnt_r != {LEN_WIDTH{1'b0}})) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_DRAIN: accept_s = 1'b1;
            default: begin
                accept_s = 1'b0;
                req_s    = 1'b0;
            end
        endcase
        out_valid_s = accept_s && (fifo_count_r != {CW{1'b0}});
        pop_s       = out_valid_s && out_ready;
        // Responses outside READ/DRAIN are stale and dropped.
        push_s      = accept_s && ram_read_ready;
    end

    // Address, issue/output counters and in-flight tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r      <= {AW{1'b0}};
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            out_cnt_r   <= {LEN_WIDTH{1'b0}};
            inflight_r  <= {CW{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                addr_r      <= start_addr;
                issue_cnt_r <= len;
                out_cnt_r   <= len;
            end else begin
                if (req_s) begin
                    addr_r      <= (addr_r == ADDR_LAST) ? {AW{1'b0}} : (addr_r + AW'(1));
                    issue_cnt_r <= issue_cnt_r - LEN_ONE;
                end
                if (pop_s) begin
                    out_cnt_r <= out_cnt_r - LEN_ONE;
                end
            end
            case ({req_s, push_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Latency-absorbing FIFO; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= ram_read_out;
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PW{1'b0}} : (wr_ptr_r + PW'(1));
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PW{1'b0}} : (rd_ptr_r + PW'(1));
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Registered status: busy follows the next state, done fires after completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= ((state_r == ST_IDLE) && start && (len == {LEN_WIDTH{1'b0}})) ||
                      ((state_r == ST_DRAIN) && pop_s && (out_cnt_r == LEN_ONE));
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign ram_read_req  = req_s;
    assign ram_read_addr = addr_r;
    assign out_valid     = out_valid_s;
    assign out_data      = out_valid_s ? fifo_mem_r[rd_ptr_r] : 8'h00;
    assign out_last      = out_valid_s && (out_cnt_r == LEN_ONE);

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Directed bench for packet_buffer_reader with a 2-cycle BRAM model (mem[i] = i & 0xFF).
module tb_packet_buffer_reader;

    localparam int RAM_SIZE = 2048;
    localparam int AW       = 11;
    localparam int LW       = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, ram_read_req, ram_read_ready;
    logic [AW-1:0] ram_read_addr;
    logic [7:0]    ram_read_out;
    logic          out_valid, out_last;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;

    // BRAM model delay line, deliberately never reset.
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [AW-1:0] p1_a = '0, p2_a = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Monitor log
    logic [7:0] rx_q[$];
    logic       rxl_q[$];
    int         req_q[$];
    int         req_cyc_q[$];
    int first_valid, last_valid, valid_cnt, busy_cnt, done_cnt, done_cyc, last_hs, start_cyc;
    int credit_viol, hold_viol, max_occ;
    int tb_infl = 0, tb_fifo = 0;
    bit tb_stream = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    packet_buffer_reader #(
        .RAM_SIZE(RAM_SIZE), .READ_LATENCY(2), .FIFO_DEPTH(4), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
        .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        p1_v <= ram_read_req;
        p1_a <= ram_read_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign ram_read_ready = p2_v;
    assign ram_read_out   = p2_a[7:0];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rx_q.delete(); rxl_q.delete(); req_q.delete(); req_cyc_q.delete();
        first_valid = -1; last_valid = -1; valid_cnt = 0; busy_cnt = 0;
        done_cnt = 0; done_cyc = -1; last_hs = -1; start_cyc = -1;
        credit_viol = 0; hold_viol = 0; max_occ = 0;
    endtask

    always @(negedge rst_n) begin
        tb_infl = 0; tb_fifo = 0; tb_stream = 1'b0; prev_stall = 1'b0;
    end

    // Sample between edges: inputs are driven on the falling edge, this runs 2 units later.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            automatic bit hs = out_valid && out_ready;
            automatic bit acc = tb_stream && ram_read_ready;
            if (busy) busy_cnt++;
            if (ram_read_req) begin
                req_q.push_back(int'(ram_read_addr));
                req_cyc_q.push_back(cyc);
                if (tb_infl + tb_fifo >= 4) credit_viol++;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (hs) begin
                rx_q.push_back(out_data);
                rxl_q.push_back(out_last);
                if (out_last) last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                tb_stream = 1'b0;
            end
            tb_infl = tb_infl + int'(ram_read_req) - int'(acc);
            tb_fifo = tb_fifo + int'(acc) - int'(hs);
            if (tb_infl + tb_fifo > max_occ) max_occ = tb_infl + tb_fifo;
            if (start && !busy) begin
                start_cyc = cyc;
                if (len != '0) tb_stream = 1'b1;
            end
        end
    end

    task automatic do_start(input int a, input int l);
        @(negedge clk);
        start = 1'b1; start_addr = AW'(a); len = LW'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        int bad = 0;
        int lasts = 0;
        logic [7:0] e;
        check_val({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < rx_q.size(); i++) begin
            e = 8'((base + i) % RAM_SIZE);
            if (rx_q[i] !== e) bad++;
            if (rxl_q[i]) begin
                lasts++;
                if (i != n - 1) bad++;
            end
        end
        check_val({tag, "_data"}, bad, 0);
        check_val({tag, "_last"}, lasts, 1);
    endtask

    task automatic check_reqs(input string tag, input int base, input int n);
        int bad = 0;
        check_val({tag, "_req_count"}, req_q.size(), n);
        for (int i = 0; i < req_q.size(); i++) begin
            if (req_q[i] != (base + i) % RAM_SIZE) bad++;
            if (req_cyc_q[i] != start_cyc + 1 + i) bad++;
        end
        check_val({tag, "_req_addr"}, bad, 0);
    endtask

    task automatic check_busy_flush(input string tag);
        @(negedge clk); check_val({tag, "_flush_busy1"}, busy, 1'b1);
        @(negedge clk); check_val({tag, "_flush_busy2"}, busy, 1'b1);
        @(negedge clk); check_val({tag, "_flush_idle"}, busy, 1'b0);
    endtask

    initial begin
        clear_log();
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_outputs", {busy, done, ram_read_req, out_valid, out_last, out_data}, 32'd0);
        check_val("rst_addr", ram_read_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_busy_flush("rst");

        // 1: basic stream, latency and done timing
        clear_log();
        do_start(10, 5);
        wait_done("t1", 100);
        check_reqs("t1", 10, 5);
        check_val("t1_latency", first_valid - start_cyc, 4);
        check_stream("t1", 10, 5);
        check_val("t1_done_after_last", done_cyc - last_hs, 1);
        check_val("t1_done_once", done_cnt, 1);

        // 2: ring wrap-around
        clear_log();
        do_start(2046, 4);
        wait_done("t2", 100);
        check_reqs("t2", 2046, 4);
        check_stream("t2", 2046, 4);

        // 3: backpressure after the first byte
        clear_log();
        do_start(100, 20);
        begin
            int k = 0;
            while (rx_q.size() < 1 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        wait_done("t3", 200);
        check_stream("t3", 100, 20);
        check_val("t3_req_total", req_q.size(), 20);
        check_val("t3_max_occ", max_occ, 4);
        check_val("t3_credit_viol", credit_viol, 0);
        check_val("t3_hold_viol", hold_viol, 0);

        // 4: zero length
        clear_log();
        do_start(5, 0);
        repeat (6) @(negedge clk);
        check_val("t4_done_latency", done_cyc - start_cyc, 1);
        check_val("t4_done_once", done_cnt, 1);
        check_val("t4_no_req", req_q.size(), 0);
        check_val("t4_no_valid", valid_cnt, 0);
        check_val("t4_no_busy", busy_cnt, 0);

        // 5a: start while busy is ignored
        clear_log();
        do_start(200, 8);
        repeat (2) @(negedge clk);
        start = 1'b1; start_addr = AW'(500); len = LW'(3);
        @(negedge clk);
        start = 1'b0;
        wait_done("t5a", 100);
        check_stream("t5a", 200, 8);
        check_val("t5a_req_total", req_q.size(), 8);
        check_val("t5a_done_once", done_cnt, 1);

        // 5b: reset with responses in flight
        clear_log();
        do_start(300, 10);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("t5_rst_outputs", {busy, done, ram_read_req, out_valid, out_last, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        check_busy_flush("t5");
        do_start(0, 3);
        wait_done("t5b", 100);
        check_stream("t5b", 0, 3);
        check_val("t5b_done_once", done_cnt, 1);

        // 6: long stream at full throughput
        clear_log();
        do_start(1000, 100);
        wait_done("t6", 300);
        check_val("t6_valid_cycles", valid_cnt, 100);
        check_val("t6_valid_span", last_valid - first_valid, 99);
        check_stream("t6", 1000, 100);
        check_val("t6_done_once", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/packet_buffer_reader.md
Name: packet_buffer_reader

Overview:
Downstream consumer of the packet buffer BRAM manager. On a start command it streams a byte range out of the packet buffer. It issues read requests with ring wrap-around and absorbs the fixed read latency in a small credit-controlled FIFO. It presents a valid/ready byte stream with a last-byte marker to the next stage, such as the MAC transmit path or the cipher engine.

Parameters:
RAM_SIZE, 2048, packet buffer depth in bytes; need not be a power of two.
READ_LATENCY, 2, cycles from ram_read_req to ram_read_ready; must equal the BRAM manager latency.
FIFO_DEPTH, 4, output FIFO entries; must be ≥ READ_LATENCY+2.
LEN_WIDTH, 11, width of the length field.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle command strobe.
start_addr  in  clog2(RAM_SIZE)  first byte address.
len  in  LEN_WIDTH  byte count.
busy  out  1  high in FLUSH/READ/DRAIN.
done  out  1  one-cycle pulse at stream completion.
ram_read_req  out  1  read strobe to BRAM manager.
ram_read_addr  out  clog2(RAM_SIZE)  read address.
ram_read_ready  in  1  read data valid.
ram_read_out  in  8  read data.
out_valid  out  1  stream byte valid.
out_data  out  8  stream byte.
out_last  out  1  final byte of stream; qualified by out_valid.
out_ready  in  1  downstream accepts byte.

Behaviour:
- Reset (reset=0), asynchronous:
  - All outputs go to 0, FIFO is emptied and counters are cleared.
  - The state goes to FLUSH.
- FLUSH:
  - busy=1; lasts READ_LATENCY cycles after reset release, then goes to IDLE.
  - ram_read_ready is discarded, so stale responses from the un-reset delay line never enter the FIFO.
- IDLE:
  - busy=0.
  - start with len≠0: latch start_addr into addr and len into the issue and output counters, go to READ.
  - start with len=0: done pulses the next cycle, no reads, stay IDLE.
  - ram_read_ready is discarded.
- READ:
  - ram_read_req=1 with ram_read_addr=addr when inflight+fifo_count < FIFO_DEPTH (registered values; pops in the same cycle are not credited). At most one request per cycle.
  - First request occurs in the cycle after start is sampled.
  - After each request, addr increments and wraps RAM_SIZE-1 → 0; the issue count decrements.
  - When the last request has issued, go to DRAIN.
- Response handling:
  - inflight += request, −= ram_read_ready.
  - Each ram_read_ready pushes ram_read_out into the FIFO. The credit rule guarantees no overflow; an overflow is a design error.
- Output:
  - out_valid = FIFO non-empty while in READ/DRAIN; out_data = FIFO head.
  - Pop happens on out_valid & out_ready.
  - out_last=1 when the output counter equals 1 (head is the final byte).
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Latency: with out_ready=1, out_valid first rises READ_LATENCY+2 cycles after the start cycle.
- Throughput: sustained one byte per cycle when out_ready=1.
- DRAIN: after the handshake on the out_last byte, go to IDLE and pulse done the following cycle. The state is IDLE in the done cycle.
- start while busy is ignored and has no effect on the current stream.
- Simultaneous push and pop on one cycle: fifo_count is unchanged.

Test Plan:
1. Preload mem[i]=i&0xFF. After reset release, wait 2 cycles. start addr=10 len=5 with out_ready=1 → ram_read_addr 10..14 on consecutive cycles; out_data 0x0A..0x0E; first out_valid at start+4; out_last only on 0x0E; done one cycle after that handshake.
2. Wrap: start addr=2046 len=4 → reads 2046, 2047, 0, 1; out_data 0xFE, 0xFF, 0x00, 0x01.
3. Backpressure: len=20, out_ready=0 for 10 cycles after the first byte → ram_read_req stops once inflight+count=4; no FIFO overflow; all 20 bytes delivered in order with no duplicates.
4. start len=0 → done pulse next cycle; out_valid and ram_read_req never assert; busy stays 0.
5. start pulsed mid-stream with a different addr → ignored. Assert reset mid-stream while responses are in flight → outputs 0 immediately; busy=1 for 2 cycles after release; stale ram_read_ready dropped; a following start addr=0 len=3 yields exactly mem[0..2].
6. len=100, out_ready=1 → out_valid high 100 consecutive cycles, exactly one out_last, done once.
